// File: rtl/memory_controller.sv
// memory_controller: sole owner of the byte-wide RAM/IO port. Arbitrates between
// instruction fetch (32-bit word reads) and the load/store buffer, sequences each access
// one byte per cycle, and returns assembled, sign/zero-extended load data.
module memory_controller #(
    parameter int unsigned IO_SEL_HI = 17,
    parameter int unsigned IO_SEL_LO = 16,
    parameter logic [5:0]  OP_LB     = 6'd0,
    parameter logic [5:0]  OP_LH     = 6'd1,
    parameter logic [5:0]  OP_LW     = 6'd2,
    parameter logic [5:0]  OP_LBU    = 6'd3,
    parameter logic [5:0]  OP_LHU    = 6'd4,
    parameter logic [5:0]  OP_SB     = 6'd5,
    parameter logic [5:0]  OP_SH     = 6'd6,
    parameter logic [5:0]  OP_SW     = 6'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_valid,
    input  logic        mem_ls,
    input  logic [5:0]  mem_ls_opcode,
    input  logic [31:0] mem_ls_addr,
    input  logic [31:0] mem_s_data,
    output logic        mem_l_valid,
    output logic [31:0] mem_l_data,
    input  logic        flush
);

    typedef enum logic [2:0] {StIdle, StIfRd, StLsRd, StLsWr, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [5:0]  op_q;
    logic        is_if_q;
    logic [23:0] buf_q;
    logic [31:0] if_data_q;
    logic [31:0] l_data_q;

    logic [31:0] cur_addr;
    logic        stall;
    logic        accept_ls;
    logic        accept_if;
    logic        rd_active;
    logic        finish_rd;
    logic [31:0] raw;
    logic [31:0] ext;
    logic [7:0]  wr_byte;

    function automatic logic [2:0] ls_len(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) begin
            return 3'd4;
        end else if (op == OP_LH || op == OP_LHU || op == OP_SH) begin
            return 3'd2;
        end else if (op == OP_LB || op == OP_LBU || op == OP_SB) begin
            return 3'd1;
        end
        return 3'd4;
    endfunction

    assign cur_addr  = base_q + {29'd0, cnt_q};
    // Only IO writes can be back-pressured; RAM writes never stall.
    assign stall     = (&cur_addr[IO_SEL_HI:IO_SEL_LO]) && io_buffer_full;
    assign accept_ls = (state_q == StIdle) && mem_valid;
    assign accept_if = (state_q == StIdle) && !mem_valid && if_valid && !flush;
    assign rd_active = (state_q == StIfRd) || (state_q == StLsRd);
    // The last byte is on mem_din when the counter has run past the final address.
    assign finish_rd = rd_active && (cnt_q == len_q) && !((state_q == StIfRd) && flush);

    // Assemble the final word from captured bytes plus the byte arriving this cycle.
    always_comb begin
        raw = 32'd0;
        case (len_q)
            3'd1:    raw = {24'd0, mem_din};
            3'd2:    raw = {16'd0, mem_din, buf_q[7:0]};
            default: raw = {mem_din, buf_q};
        endcase
    end

    // Sign-extend signed sub-word loads; unsigned ones are already zero-filled.
    always_comb begin
        ext = raw;
        if (op_q == OP_LB) begin
            ext = {{24{raw[7]}}, raw[7:0]};
        end else if (op_q == OP_LH) begin
            ext = {{16{raw[15]}}, raw[15:0]};
        end
    end

    // Select the store byte for the current position.
    always_comb begin
        wr_byte = 8'd0;
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    // FSM state and byte counter; everything freezes while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (mem_valid) begin
                    state_d = mem_ls ? StLsRd : StLsWr;
                end else if (if_valid && !flush) begin
                    state_d = StIfRd;
                end
            end
            StIfRd: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else if (cnt_q == len_q) begin
                    state_d = StDone;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StLsRd: begin
                if (cnt_q == len_q) begin
                    state_d = StDone;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StLsWr: begin
                if (!stall) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d = StDone;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Request latching, byte capture and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= 3'd0;
            base_q    <= 32'd0;
            wdata_q   <= 32'd0;
            op_q      <= 6'd0;
            is_if_q   <= 1'b0;
            buf_q     <= 24'd0;
            if_data_q <= 32'd0;
            l_data_q  <= 32'd0;
        end else if (rdy) begin
            if (accept_ls) begin
                base_q  <= mem_ls_addr;
                op_q    <= mem_ls_opcode;
                len_q   <= ls_len(mem_ls_opcode);
                wdata_q <= mem_s_data;
                is_if_q <= 1'b0;
            end else if (accept_if) begin
                base_q  <= if_addr;
                op_q    <= OP_LW;
                len_q   <= 3'd4;
                is_if_q <= 1'b1;
            end
            if (rd_active) begin
                case (cnt_q)
                    3'd1:    buf_q[7:0]   <= mem_din;
                    3'd2:    buf_q[15:8]  <= mem_din;
                    3'd3:    buf_q[23:16] <= mem_din;
                    default: ;
                endcase
            end
            if (finish_rd) begin
                if (is_if_q) begin
                    if_data_q <= raw;
                end else begin
                    l_data_q <= ext;
                end
            end
        end
    end

    // Port drive decoded from the current state.
    always_comb begin
        mem_a       = 32'd0;
        mem_wr      = 1'b0;
        mem_dout    = 8'd0;
        if_done     = 1'b0;
        mem_l_valid = 1'b0;
        unique case (state_q)
            StIfRd, StLsRd: begin
                mem_a = cur_addr;
            end
            StLsWr: begin
                mem_a    = cur_addr;
                mem_dout = wr_byte;
                mem_wr   = !stall;
            end
            StDone: begin
                // A flush landing on a fetch completion swallows the pulse.
                if (is_if_q) begin
                    if_done = rdy && !flush;
                end else begin
                    mem_l_valid = rdy;
                end
            end
            default: ;
        endcase
    end

    assign if_data    = if_data_q;
    assign mem_l_data = l_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a small byte RAM model with one-cycle read
// latency answers mem_a; inputs change 1 time unit after the rising edge and outputs are
// sampled after that.
module tb_memory_controller;

    localparam logic [5:0] OP_LB  = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd5;
    localparam logic [5:0] OP_SH  = 6'd6;
    localparam logic [5:0] OP_SW  = 6'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_valid;
    logic        mem_ls;
    logic [5:0]  mem_ls_opcode;
    logic [31:0] mem_ls_addr;
    logic [31:0] mem_s_data;
    logic        mem_l_valid;
    logic [31:0] mem_l_data;
    logic        flush;

    int checks = 0;
    int failures = 0;

    memory_controller dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_valid       (if_valid),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .mem_valid      (mem_valid),
        .mem_ls         (mem_ls),
        .mem_ls_opcode  (mem_ls_opcode),
        .mem_ls_addr    (mem_ls_addr),
        .mem_s_data     (mem_s_data),
        .mem_l_valid    (mem_l_valid),
        .mem_l_data     (mem_l_data),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] addr);
        case (addr)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h200: return 8'h80;
            32'h201: return 8'h34;
            32'h202: return 8'h92;
            default: return 8'h00;
        endcase
    endfunction

    // RAM answers one cycle after the address.
    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] sw_data;
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        if_valid = 1'b0; if_addr = 32'd0;
        mem_valid = 1'b0; mem_ls = 1'b0; mem_ls_opcode = 6'd0;
        mem_ls_addr = 32'd0; mem_s_data = 32'd0;
        cyc(); cyc();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_l_valid", {31'd0, mem_l_valid}, 32'd0);
        chk("rst_l_data", mem_l_data, 32'd0);
        rst = 1'b1;
        cyc();

        // Fetch of 0x100: addresses in cycles 1-4, if_done in cycle 6.
        if_valid = 1'b1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("fetch_addr", mem_a, 32'h100 + k);
            chk("fetch_wr", {31'd0, mem_wr}, 32'd0);
        end
        cyc(); chk("fetch_done_early", {31'd0, if_done}, 32'd0);
        cyc(); chk("fetch_done", {31'd0, if_done}, 32'd1);
        chk("fetch_data", if_data, 32'h0000_0513);
        if_valid = 1'b0;
        cyc(); chk("fetch_done_once", {31'd0, if_done}, 32'd0);

        // LB 0x200 -> 0x80 sign-extended, done in cycle 3.
        mem_valid = 1'b1; mem_ls = 1'b1; mem_ls_opcode = OP_LB; mem_ls_addr = 32'h200;
        cyc(); chk("lb_addr", mem_a, 32'h200);
        cyc(); chk("lb_valid_early", {31'd0, mem_l_valid}, 32'd0);
        cyc(); chk("lb_valid", {31'd0, mem_l_valid}, 32'd1);
        chk("lb_data", mem_l_data, 32'hFFFF_FF80);
        mem_valid = 1'b0;
        cyc();

        // LHU 0x201 -> bytes 0x34,0x92 zero-extended, done in cycle 4.
        mem_valid = 1'b1; mem_ls_opcode = OP_LHU; mem_ls_addr = 32'h201;
        cyc(); cyc(); cyc(); chk("lhu_valid_early", {31'd0, mem_l_valid}, 32'd0);
        cyc(); chk("lhu_valid", {31'd0, mem_l_valid}, 32'd1);
        chk("lhu_data", mem_l_data, 32'h0000_9234);
        mem_valid = 1'b0;
        cyc();

        // SW 0x11223344 to 0x1000, little-endian byte order.
        sw_data = 32'h1122_3344;
        mem_valid = 1'b1; mem_ls = 1'b0; mem_ls_opcode = OP_SW; mem_ls_addr = 32'h1000;
        mem_s_data = sw_data;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("sw_wr", {31'd0, mem_wr}, 32'd1);
            chk("sw_addr", mem_a, 32'h1000 + k);
            chk("sw_byte", {24'd0, mem_dout}, (sw_data >> (8 * k)) & 32'hFF);
        end
        cyc(); chk("sw_valid", {31'd0, mem_l_valid}, 32'd1);
        chk("sw_ldata_held", mem_l_data, 32'h0000_9234);
        mem_valid = 1'b0;
        cyc();

        // SB to IO address with the IO buffer full for three cycles.
        mem_valid = 1'b1; mem_ls_opcode = OP_SB; mem_ls_addr = 32'h0003_0000;
        mem_s_data = 32'h0000_0041; io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("sb_stall_wr", {31'd0, mem_wr}, 32'd0);
            chk("sb_stall_valid", {31'd0, mem_l_valid}, 32'd0);
        end
        cyc(); io_buffer_full = 1'b0; #1;
        chk("sb_wr", {31'd0, mem_wr}, 32'd1);
        chk("sb_byte", {24'd0, mem_dout}, 32'h41);
        chk("sb_addr", mem_a, 32'h0003_0000);
        cyc(); chk("sb_valid", {31'd0, mem_l_valid}, 32'd1);
        mem_valid = 1'b0;
        cyc();

        // SH at 0xFFFFFFFF wraps to address 0 for the second byte.
        mem_valid = 1'b1; mem_ls_opcode = OP_SH; mem_ls_addr = 32'hFFFF_FFFF;
        mem_s_data = 32'h0000_ABCD;
        cyc();
        chk("sh_addr0", mem_a, 32'hFFFF_FFFF);
        chk("sh_byte0", {24'd0, mem_dout}, 32'hCD);
        chk("sh_wr0", {31'd0, mem_wr}, 32'd1);
        cyc();
        chk("sh_addr1", mem_a, 32'h0);
        chk("sh_byte1", {24'd0, mem_dout}, 32'hAB);
        cyc(); chk("sh_valid", {31'd0, mem_l_valid}, 32'd1);
        mem_valid = 1'b0;
        cyc();

        // Simultaneous requests: LSB first, fetch after DONE->IDLE.
        if_valid = 1'b1; if_addr = 32'h100;
        mem_valid = 1'b1; mem_ls = 1'b1; mem_ls_opcode = OP_LB; mem_ls_addr = 32'h200;
        cyc(); chk("arb_lsb_first", mem_a, 32'h200);
        cyc(); cyc();
        chk("arb_lsb_valid", {31'd0, mem_l_valid}, 32'd1);
        chk("arb_lsb_data", mem_l_data, 32'hFFFF_FF80);
        chk("arb_no_if_done", {31'd0, if_done}, 32'd0);
        mem_valid = 1'b0;
        cyc();
        cyc(); chk("arb_fetch_addr", mem_a, 32'h100);
        cyc(); cyc(); cyc(); cyc();
        chk("arb_fetch_early", {31'd0, if_done}, 32'd0);
        cyc(); chk("arb_fetch_done", {31'd0, if_done}, 32'd1);
        chk("arb_fetch_data", if_data, 32'h0000_0513);
        if_valid = 1'b0;
        cyc();

        // Flush at fetch byte 2; a new fetch issued the next cycle must start at once.
        if_valid = 1'b1; if_addr = 32'h100;
        cyc(); cyc(); cyc();
        chk("flush_byte2_addr", mem_a, 32'h102);
        flush = 1'b1; if_valid = 1'b0;
        cyc();
        flush = 1'b0; if_valid = 1'b1; if_addr = 32'h200;
        chk("flush_wr", {31'd0, mem_wr}, 32'd0);
        cyc(); chk("flush_refetch_addr", mem_a, 32'h200);
        for (int k = 0; k < 4; k++) begin
            chk("flush_no_done", {31'd0, if_done}, 32'd0);
            cyc();
        end
        chk("flush_no_done", {31'd0, if_done}, 32'd0);
        cyc(); chk("refetch_done", {31'd0, if_done}, 32'd1);
        chk("refetch_data", if_data, 32'h0092_3480);
        if_valid = 1'b0;
        cyc();

        // Flush during an LW is ignored.
        mem_valid = 1'b1; mem_ls = 1'b1; mem_ls_opcode = OP_LW; mem_ls_addr = 32'h200;
        cyc(); cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;
        cyc(); cyc(); chk("lw_flush_early", {31'd0, mem_l_valid}, 32'd0);
        cyc(); chk("lw_flush_valid", {31'd0, mem_l_valid}, 32'd1);
        chk("lw_flush_data", mem_l_data, 32'h0092_3480);
        mem_valid = 1'b0;
        cyc();

        // Reset mid-LW at byte 1: outputs clear at once, no stray completion later.
        mem_valid = 1'b1; mem_ls_opcode = OP_LW; mem_ls_addr = 32'h100;
        cyc(); cyc();
        rst = 1'b0; mem_valid = 1'b0;
        #1;
        chk("mrst_mem_a", mem_a, 32'd0);
        chk("mrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("mrst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("mrst_l_valid", {31'd0, mem_l_valid}, 32'd0);
        chk("mrst_l_data", mem_l_data, 32'd0);
        chk("mrst_if_data", if_data, 32'd0);
        chk("mrst_if_done", {31'd0, if_done}, 32'd0);
        cyc(); rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("mrst_no_valid", {31'd0, mem_l_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Single owner of the byte-wide external RAM/IO port.
- Arbitrates between instruction fetch (always 32-bit word reads) and the load/store buffer (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Sequences each multi-byte access one byte per cycle and returns assembled, sign/zero-extended load data.
- The load/store buffer sees this block as its "MC" via the mem_valid / mem_l_valid handshake.

Parameters:
- IO_SEL_HI, 17: top bit of the IO-region select field.
- IO_SEL_LO, 16: bottom bit of the IO-region select field. An address is IO when addr[IO_SEL_HI:IO_SEL_LO] == 2'b11.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- mem_din  in  8  RAM/IO read byte.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  IO write buffer full.
- if_valid  in  1  fetch request, level.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse; if_data is valid.
- if_data  out  32  fetched word.
- mem_valid  in  1  LSB request, level.
- mem_ls  in  1  1 = load, 0 = store.
- mem_ls_opcode  in  6  `LB..`SW from config.vh.
- mem_ls_addr  in  32  LSB address.
- mem_s_data  in  32  store data; low bytes are used.
- mem_l_valid  out  1  one-cycle pulse; access complete (loads and stores).
- mem_l_data  out  32  extended load data.
- flush  in  1  mispredict flush from CDB.

Behaviour:
- Reset: rst low clears everything immediately, regardless of clk.
  - Outputs: mem_dout=0, mem_a=0, mem_wr=0, if_done=0, if_data=0, mem_l_valid=0, mem_l_data=0.
  - State = IDLE; byte counter = 0.
  - Reset mid-access abandons the access; no done pulse is produced.
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
- Access length n:
  - 4 for fetch, LW, SW.
  - 2 for LH, LHU, SH.
  - 1 for LB, LBU, SB.
- IDLE (mem_wr=0, both done pulses low):
  - mem_valid wins over if_valid when both are high (fixed LSB priority).
  - Accepted LSB load -> LS_RD; accepted LSB store -> LS_WR; accepted fetch -> IF_RD.
  - Request fields are latched at acceptance; later changes on the inputs are ignored.
  - A fetch is not accepted in a cycle where flush=1.
- Byte issue: byte k (k=0..n-1) goes to address base+k, 32-bit wrap. No alignment requirement.
- Reads (IF_RD, LS_RD):
  - mem_a=base+k, mem_wr=0 in cycle k+1 after acceptance.
  - mem_din carries byte k one cycle after its address; it is stored little-endian into bits [8k+7:8k].
  - After the last byte is captured -> DONE.
  - Request sampled in cycle 0; done pulse in cycle n+2.
- Writes (LS_WR):
  - mem_wr=1, mem_a=base+k, mem_dout=mem_s_data[8k+7:8k], one byte per cycle.
  - IO stall: if the address is IO and io_buffer_full=1, that cycle drives mem_wr=0 with the counter held, and the byte is retried next cycle.
  - After byte n-1 -> DONE; done pulse in cycle n+1 when there is no stall.
- DONE:
  - Exactly one cycle: if_done=1 for fetch, otherwise mem_l_valid=1.
  - Data outputs are stable in this cycle and held until the next completion.
  - Stores pulse mem_l_valid with mem_l_data unchanged.
  - Next state is always IDLE. Requests are not sampled in DONE, because the requester drops its level the cycle after the pulse.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW and fetch pass all 32 bits.
- Flush:
  - In IF_RD (or DONE of a fetch): abort at the next edge, go to IDLE, drive mem_wr=0, no if_done.
  - LSB accesses ignore flush and always complete; stores must never be torn.
- rdy=0: freeze in place, including the byte counter and pending pulses. The one-cycle pulse resumes when rdy returns.
- Between accesses (IDLE) the controller never asserts mem_wr.

Test Plan:
- Fetch: if_valid=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_data=0x00000513; mem_wr stays 0 throughout.
- Sign/zero extension: LB at 0x200 with RAM=0x80 -> mem_l_data=0xFFFFFF80 in cycle 3. LHU at 0x201 with bytes 0x34,0x92 -> 0x00009234.
- Store: SW 0x11223344 to 0x1000 -> mem_wr=1 with bytes 44,33,22,11 at 0x1000..0x1003 in cycles 1-4; mem_l_valid in cycle 5.
- IO stall and address wrap:
  - SB 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr low for those cycles, then one write of 0x41; mem_l_valid follows.
  - SH to 0xFFFFFFFF -> second byte goes to address 0x00000000.
- Arbitration and flush:
  - if_valid and mem_valid both rise in the same cycle -> the LSB access completes first, the fetch starts after DONE->IDLE.
  - flush pulse at fetch byte 2 -> no if_done, IDLE next cycle.
  - flush during an LW -> the load still completes with correct data.
- Reset mid-LW: rst low at byte 1 -> all outputs 0 immediately; after release no mem_l_valid appears until a new request is made.
